// File: rtl/tx_arbiter.sv
// tx_arbiter: round-robin arbiter that shares one tx serializer between
// NUM_REQ requesters through the tx_start / tx_pi / tx_busy handshake.
// Optional feature macro: TX_ARB_TIMEOUT_EN. When it is defined, a grant
// that never sees tx_busy rise within TIMEOUT_CYCLES START cycles is retired
// with an ack plus a timeout_err pulse. Without it, START waits indefinitely.
module tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int WIDTH          = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         grant,
    output logic [NUM_REQ-1:0]         ack,
    output logic                       tx_start,
    output logic [WIDTH-1:0]           tx_pi,
    input  logic                       tx_busy,
    output logic                       arb_busy,
    output logic                       timeout_err
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] owner;
    logic [PTR_W-1:0] winner;
    logic [PTR_W-1:0] scan_idx;
    logic             found;
    logic [PTR_W-1:0] next_ptr;

`ifdef TX_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] tmo_cnt;
`else
    assign timeout_err = 1'b0;
`endif

    // Every state except IDLE counts as busy; state is registered so this is glitch-free.
    assign arb_busy = (state != IDLE);

    // Owner's successor with explicit wrap so non-power-of-two NUM_REQ works.
    assign next_ptr = (owner == LAST_IDX) ? '0 : owner + 1'b1;

    // Round-robin search starting at ptr, wrapping modulo NUM_REQ.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_idx = ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[scan_idx]) begin
                found  = 1'b1;
                winner = scan_idx;
            end
            scan_idx = (scan_idx == LAST_IDX) ? '0 : scan_idx + 1'b1;
        end
    end

    // Transaction FSM with registered grant/ack/tx_start/tx_pi outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            owner    <= '0;
            grant    <= '0;
            ack      <= '0;
            tx_start <= 1'b0;
            tx_pi    <= '0;
`ifdef TX_ARB_TIMEOUT_EN
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // Holding off while tx_busy is high lets an in-flight frame finish.
                    if (found && !tx_busy) begin
                        owner    <= winner;
                        grant    <= ONE_HOT0 << winner;
                        tx_pi    <= req_data[int'(winner)*WIDTH +: WIDTH];
                        tx_start <= 1'b1;
                        state    <= START;
`ifdef TX_ARB_TIMEOUT_EN
                        tmo_cnt  <= '0;
`endif
                    end
                end
                START: begin
                    if (tx_busy) begin
                        tx_start <= 1'b0;
                        state    <= SEND;
                    end
`ifdef TX_ARB_TIMEOUT_EN
                    else if (tmo_cnt == CNT_LAST) begin
                        // Serializer never accepted the byte: retire the grant anyway.
                        tx_start    <= 1'b0;
                        grant       <= '0;
                        ack         <= ONE_HOT0 << owner;
                        timeout_err <= 1'b1;
                        ptr         <= next_ptr;
                        state       <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                SEND: begin
                    if (!tx_busy) begin
                        ack   <= ONE_HOT0 << owner;
                        grant <= '0;
                        ptr   <= next_ptr;
                        state <= DONE;
                    end
                end
                DONE: begin
                    ack   <= '0;
                    state <= IDLE;
`ifdef TX_ARB_TIMEOUT_EN
                    timeout_err <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_arbiter.sv
// Scoreboard bench for tx_arbiter: directed transactions push their expected
// grant/byte/ack into a queue; a negedge monitor pops and compares.
module tb_tx_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   grant;
    logic [N-1:0]   ack;
    logic           tx_start;
    logic [W-1:0]   tx_pi;
    logic           tx_busy;
    logic           arb_busy;
    logic           timeout_err;

    logic [W-1:0] data [N];
    logic         force_busy;
    logic         mdl_busy;
    logic         stuck;
    int           mstate;
    int           bcnt;
    int           rem [N];
    int           ack_total;
    int           exp_acks;
    int           total;
    int           passed;

    typedef struct {
        logic [N-1:0] g;
        logic [W-1:0] d;
        bit           to;
        int           slen;
    } exp_t;

    exp_t exp_q[$];

    assign req_data = {data[3], data[2], data[1], data[0]};
    assign tx_busy  = force_busy | mdl_busy;

    tx_arbiter #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
        .grant(grant), .ack(ack), .tx_start(tx_start), .tx_pi(tx_pi),
        .tx_busy(tx_busy), .arb_busy(arb_busy), .timeout_err(timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    function automatic bit rem_any();
        for (int i = 0; i < N; i++) if (rem[i] != 0) return 1'b1;
        return 1'b0;
    endfunction

    // One clock: serializer model and requesters react just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (mstate == 0) begin
            if (tx_start && !stuck && rst_n) begin
                mdl_busy = 1'b1;
                bcnt     = 11;
                mstate   = 1;
            end
        end else begin
            bcnt--;
            if (bcnt == 0) begin
                mdl_busy = 1'b0;
                mstate   = 0;
            end
        end
        if (ack != 0) begin
            ack_total++;
            if (timeout_err) stuck = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (ack[i] && rem[i] > 0) begin
                rem[i]--;
                if (rem[i] == 0) req[i] = 1'b0;
            end
        end
    endtask

    task automatic wait_done(input string name, input int bound);
        int n;
        n = 0;
        while (rem_any() && n < bound) begin
            tick();
            n++;
        end
        chk(name, int'(rem_any()), 0);
    endtask

    task automatic push(input logic [N-1:0] g, input logic [W-1:0] d, input bit to, input int slen);
        exp_t e;
        e.g = g; e.d = d; e.to = to; e.slen = slen;
        exp_q.push_back(e);
    endtask

    // Monitor: pops expectations on each tx_start rise, checks ack on completion.
    initial begin
        exp_t cur;
        bit   inflight;
        bit   prev;
        int   run;
        inflight = 0; prev = 0; run = 0;
        cur.g = '0; cur.d = '0; cur.to = 0; cur.slen = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                inflight = 0; prev = 0; run = 0;
            end else begin
                if (tx_start) begin
                    if (!prev) begin
                        run = 1;
                        if (exp_q.size() == 0) begin
                            chk("unexpected_start", 1, 0);
                        end else begin
                            cur = exp_q.pop_front();
                            chk("grant", int'(grant), int'(cur.g));
                            chk("tx_pi", int'(tx_pi), int'(cur.d));
                            inflight = 1;
                        end
                    end else begin
                        run++;
                    end
                end else if (prev) begin
                    chk("start_len", run, cur.slen);
                end
                if (ack != 0) begin
                    chk("ack_inflight", int'(inflight), 1);
                    chk("ack_owner", int'(ack), int'(cur.g));
                    chk("grant_clear_at_ack", int'(grant), 0);
                    chk("timeout_err", int'(timeout_err), int'(cur.to));
                    inflight = 0;
                end
                prev = tx_start;
            end
        end
    end

    initial begin
        total = 0; passed = 0; ack_total = 0; exp_acks = 0;
        mstate = 0; bcnt = 0; mdl_busy = 1'b0; stuck = 1'b0;
        for (int i = 0; i < N; i++) begin
            rem[i]  = 0;
            data[i] = '0;
        end
        // Reset with the serializer busy and requester 0 already waiting
        rst_n = 1'b0; force_busy = 1'b1; req = 4'b0001; data[0] = 8'h5A;
        #2;
        chk("rst_grant", int'(grant), 0);
        chk("rst_ack", int'(ack), 0);
        chk("rst_tx_start", int'(tx_start), 0);
        chk("rst_tx_pi", int'(tx_pi), 0);
        chk("rst_arb_busy", int'(arb_busy), 0);
        chk("rst_timeout_err", int'(timeout_err), 0);
        tick(); tick();
        rst_n = 1'b1;
        rem[0] = 1; push(4'b0001, 8'h5A, 0, 1); exp_acks += 1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("busy_hold_start", int'(tx_start), 0);
            chk("busy_hold_arb", int'(arb_busy), 0);
        end
        force_busy = 1'b0;
        tick();
        chk("first_start_latency", int'(tx_start), 1);
        wait_done("busy_release_done", 100);

        // Single request from requester 2
        data[2] = 8'hA5; rem[2] = 1; push(4'b0100, 8'hA5, 0, 1); exp_acks += 1;
        req = 4'b0100;
        wait_done("single_done", 100);

        // Pointer wrap: ptr=3 so requester 3 then 0
        data[3] = 8'hC3; data[0] = 8'h3C; rem[3] = 1; rem[0] = 1;
        push(4'b1000, 8'hC3, 0, 1); push(4'b0001, 8'h3C, 0, 1); exp_acks += 2;
        req = 4'b1001;
        wait_done("wrap_done", 200);

        // ptr=1 now; requester 1 alone moves ptr to 2 ... use 3 to land on 0
        data[3] = 8'h77; rem[3] = 1; push(4'b1000, 8'h77, 0, 1); exp_acks += 1;
        req = 4'b1000;
        wait_done("ptr_to_zero_done", 100);

        // Fairness: all four held, requester 0 served twice
        data[0] = 8'h10; data[1] = 8'h21; data[2] = 8'h32; data[3] = 8'h43;
        rem[0] = 2; rem[1] = 1; rem[2] = 1; rem[3] = 1;
        push(4'b0001, 8'h10, 0, 1); push(4'b0010, 8'h21, 0, 1);
        push(4'b0100, 8'h32, 0, 1); push(4'b1000, 8'h43, 0, 1);
        push(4'b0001, 8'h10, 0, 1); exp_acks += 5;
        req = 4'b1111;
        wait_done("fair_done", 400);

        // Reset in SEND aborts without ack; requester 1 is re-granted afterwards
        data[1] = 8'hE1; rem[1] = 1; push(4'b0010, 8'hE1, 0, 1);
        req = 4'b0010;
        begin
            int n;
            n = 0;
            while (!tx_start && n < 50) begin
                tick();
                n++;
            end
            chk("mid_send_start_seen", int'(tx_start), 1);
        end
        tick(); tick(); tick();
        chk("mid_send_state", int'(arb_busy), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_grant", int'(grant), 0);
        chk("abort_ack", int'(ack), 0);
        chk("abort_tx_start", int'(tx_start), 0);
        chk("abort_tx_pi", int'(tx_pi), 0);
        chk("abort_arb_busy", int'(arb_busy), 0);
        tick();
        chk("abort_ack_hold", int'(ack), 0);
        tick();
        rst_n = 1'b1;
        chk("abort_no_ack_rem", rem[1], 1);
        push(4'b0010, 8'hE1, 0, 1); exp_acks += 1;
        wait_done("after_abort_done", 100);

`ifdef TX_ARB_TIMEOUT_EN
        // Serializer ignores tx_start: requester 2 times out, requester 0 served next
        stuck = 1'b1;
        data[2] = 8'h99; data[0] = 8'h11; rem[2] = 1; rem[0] = 1;
        push(4'b0100, 8'h99, 1, 16); push(4'b0001, 8'h11, 0, 1); exp_acks += 2;
        req = 4'b0101;
        wait_done("timeout_done", 300);
`endif

        tick(); tick();
        chk("queue_empty", exp_q.size(), 0);
        chk("ack_total", ack_total, exp_acks);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/tx_arbiter.md
Name: tx_arbiter

Overview:
- Round-robin arbiter sharing one tx serializer between NUM_REQ requesters.
- Sits between the requesters and the serializer's tx_start / tx_pi / tx_busy handshake.
- Per transaction: selects one requester, latches its byte, raises tx_start until the serializer reports busy, waits for busy to drop, then acknowledges that requester.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- WIDTH, 8, data byte width; must match the serializer's WIDTH.
- TIMEOUT_CYCLES, 16, maximum cycles to wait for tx_busy after tx_start; used only with TX_ARB_TIMEOUT_EN.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  NUM_REQ  level request per requester.
- req_data  input  NUM_REQ*WIDTH  byte per requester; requester i uses bits [i*WIDTH +: WIDTH].
- grant  output  NUM_REQ  one-hot; current owner, registered.
- ack  output  NUM_REQ  one-cycle completion pulse to the owner.
- tx_start  output  1  start strobe to the serializer.
- tx_pi  output  WIDTH  byte to the serializer; held stable for the whole transaction.
- tx_busy  input  1  serializer busy flag.
- arb_busy  output  1  high in every state except IDLE.
- timeout_err  output  1  one-cycle pulse on timeout; constant 0 without the macro.

Behaviour:
- Reset (async assert, sync release): state=IDLE; ptr=0; grant, ack, tx_start, tx_pi, arb_busy, timeout_err all 0.
- Reset mid-transaction aborts at once with no ack.
- After reset, the first grant waits for tx_busy=0, so an in-flight serializer frame finishes undisturbed.
- States: IDLE, START, SEND, DONE.
- IDLE:
  - Condition: |req && !tx_busy.
  - Winner = first set req bit searching ptr, ptr+1, ... wrapping mod NUM_REQ.
  - Next edge: grant=onehot(winner), tx_pi=req_data[winner], tx_start=1, go START.
  - Latency: req high at edge k gives tx_start high after edge k+1.
- START:
  - tx_start held 1 until tx_busy is sampled 1.
  - On that edge: tx_start=0, go SEND.
- SEND:
  - Wait for tx_busy sampled 0.
  - On that edge: ack[winner]=1, grant=0, tx_pi unchanged, ptr=(winner+1) mod NUM_REQ with wrap from NUM_REQ-1 to 0, go DONE.
- DONE:
  - Lasts one cycle; ack cleared on the following edge; return to IDLE.
  - Minimum spacing between tx_start assertions is therefore START+SEND+DONE+1 IDLE cycle.
- Requester rules:
  - req is level-sensitive; hold req and req_data until ack.
  - req_data is sampled only at grant; later changes are ignored.
  - Dropping req after grant does not abort; ack still pulses.
  - Dropping req before grant withdraws the request silently.
- Simultaneous events:
  - Requester still high during its own ack is reconsidered, but after the pointer advance, so other pending requesters win first.
  - All requesters high gives strict rotation 0,1,2,3,0...
- tx_busy already high in IDLE: no grant, stay in IDLE.
- ptr width: $clog2(NUM_REQ).
- grant and ack are never nonzero in the same cycle.

Optional Feature:
- Macro: TX_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to START and increments each START cycle.
  - If tx_busy is still 0 when the count reaches TIMEOUT_CYCLES: tx_start=0, grant=0, ack[winner]=1 and timeout_err=1 for one cycle, ptr advances, go DONE.
  - Counter width: $clog2(TIMEOUT_CYCLES+1).
- Undefined: START waits indefinitely; timeout_err tied to 0; no counter logic.

Test Plan:
- Single request, tx model busy 1 cycle after start for 11 cycles: req=4'b0100, req_data[23:16]=8'hA5 -> grant=4'b0100, tx_pi=8'hA5, tx_start high 1 cycle, ack[2] single pulse after busy falls, ptr=3.
- Fairness: all four req held with bytes 8'h10/8'h21/8'h32/8'h43 -> tx_pi sequence 10,21,32,43,10; each ack exactly once per round.
- Pointer wrap: ptr=3, req=4'b1001 -> requester 3 served first, then 0; ptr ends at 1.
- Busy at reset release: tx_busy=1 for 5 cycles with req=4'b0001 -> no tx_start until the first IDLE cycle with tx_busy=0.
- Reset mid-SEND: rst_n low during SEND -> all outputs 0 immediately, no ack; after release, the same requester is granted first.
- With TX_ARB_TIMEOUT_EN: tx_busy stuck 0, TIMEOUT_CYCLES=16 -> tx_start drops after 16 START cycles; ack and timeout_err pulse together; the next requester is served.
